seq_detector_param: RTL and testbench

//  Serial bit-pattern detector, parametrised successor of the fixed 7-bit FSM detector.

---
 rtl/seq_detector_param_if.sv | 30 +++
 rtl/seq_detector_param.sv | 104 ++++++++++
 tb/tb_seq_detector_param.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// Serial receive-path bundle for seq_detector_param.
// master: drives the bit stream, pattern reload and counter clear.
// slave : the detector; returns match pulse, match count and the matched prefix length.
// Ports: in_valid/in (qualified serial bit), cfg_load/cfg_pattern (pattern reload),
//        cnt_clr (counter clear), match/match_cnt/prefix_len (detector status).
interface seq_detector_param_if #(
  parameter int PAT_LEN = 7,
  parameter int CNT_W   = 8
);
  localparam int PW = $clog2(PAT_LEN + 1);

  logic               in_valid;
  logic               in;
  logic               cfg_load;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic [PW-1:0]      prefix_len;

  modport master (
    output in_valid, in, cfg_load, cfg_pattern, cnt_clr,
    input  match, match_cnt, prefix_len
  );

  modport slave (
    input  in_valid, in, cfg_load, cfg_pattern, cnt_clr,
    output match, match_cnt, prefix_len
  );
endinterface

// File: rtl/seq_detector_param.sv
// Purpose: KMP-style detector of a runtime-reloadable PAT_LEN-bit pattern (MSB first) in a serial stream.
// Latency: match is a registered pulse in the cycle after the edge that sampled the final bit.
// Flow: no backpressure; bits are consumed only on edges with in_valid=1, state holds otherwise.
// Ports: clk, reset (async, active-high), bus (slave modport of seq_detector_param_if):
//        in_valid/in, cfg_load/cfg_pattern, cnt_clr in; match, match_cnt, prefix_len out.
module seq_detector_param #(
  parameter int                 PAT_LEN = 7,
  parameter logic [PAT_LEN-1:0] PATTERN = 7'b1010111,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);

  localparam int PW = $clog2(PAT_LEN + 1);
  typedef logic [PW-1:0] state_t;

  // State is encoded numerically as the matched prefix length (0..PAT_LEN-1).
  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;   // last PAT_LEN-1 accepted bits, newest in LSB
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] window;
  logic [PAT_LEN-1:0] mask;
  state_t             best;
  logic               full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      hist_q  <= '0;
      pat_q   <= PATTERN;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    window  = {hist_q, bus.in};
    mask    = '0;
    best    = '0;

    // Longest prefix (shorter than the full pattern) that is a suffix of the
    // stream including the incoming bit. Only the last state_q+1 bits are
    // meaningful, which is what makes bits older than a restart invisible.
    for (int k = 1; k < PAT_LEN; k++) begin
      mask = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
      if ((k <= int'(state_q) + 1) &&
          (((window ^ (pat_q >> (PAT_LEN - k))) & mask) == '0)) begin
        best = state_t'(k);
      end
    end

    full = (state_q == state_t'(PAT_LEN - 1)) && (bus.in == pat_q[0]);

    if (bus.cfg_load) begin
      // Reload wins over data: the bit on this edge is dropped.
      pat_d   = bus.cfg_pattern;
      state_d = '0;
      hist_d  = '0;
    end else if (bus.in_valid) begin
      hist_d = window[PAT_LEN-2:0];
      if (full) begin
        match_d = 1'b1;
        if (OVERLAP) begin
          // With state at PAT_LEN-1, best is the longest proper border of the pattern.
          state_d = best;
        end else begin
          state_d = '0;
          hist_d  = '0;
        end
      end else begin
        state_d = best;
      end
    end

    // A clear coinciding with a match leaves exactly that match counted.
    if (bus.cnt_clr) begin
      cnt_d = match_d ? CNT_W'(1) : '0;
    end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bus.match      = match_q;
  assign bus.match_cnt  = cnt_q;
  assign bus.prefix_len = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances share one stimulus stream:
// u_a defaults (overlap, 8-bit count), u_b non-overlap, u_c overlap with 2-bit count.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic [6:0] cfg_pattern = 7'b0;
  logic       cnt_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int ma = 0, mb = 0, mc = 0;
  int cyc = 0;
  int pos_a[$];

  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_LEN(7), .CNT_W(8)) if_a ();
  seq_detector_param_if #(.PAT_LEN(7), .CNT_W(8)) if_b ();
  seq_detector_param_if #(.PAT_LEN(7), .CNT_W(2)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_b.in_valid = in_valid;  assign if_c.in_valid = in_valid;
  assign if_a.in = din;             assign if_b.in = din;             assign if_c.in = din;
  assign if_a.cfg_load = cfg_load;  assign if_b.cfg_load = cfg_load;  assign if_c.cfg_load = cfg_load;
  assign if_a.cfg_pattern = cfg_pattern;
  assign if_b.cfg_pattern = cfg_pattern;
  assign if_c.cfg_pattern = cfg_pattern;
  assign if_a.cnt_clr = cnt_clr;    assign if_b.cnt_clr = cnt_clr;    assign if_c.cnt_clr = cnt_clr;

  seq_detector_param #(.PAT_LEN(7), .PATTERN(7'b1010111), .OVERLAP(1'b1), .CNT_W(8))
    u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  seq_detector_param #(.PAT_LEN(7), .PATTERN(7'b1010111), .OVERLAP(1'b0), .CNT_W(8))
    u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  seq_detector_param #(.PAT_LEN(7), .PATTERN(7'b1010111), .OVERLAP(1'b1), .CNT_W(2))
    u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given in_valid/in; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    din = b;
    @(posedge clk);
    #1;
    cyc++;
    if (if_a.match === 1'b1) begin ma++; pos_a.push_back(cyc); end
    if (if_b.match === 1'b1) mb++;
    if (if_c.match === 1'b1) mc++;
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    ma = 0; mb = 0; mc = 0;
    pos_a.delete();
  endtask

  initial begin
    int exp4 [7];
    logic [6:0] p4;
    exp4 = '{1, 2, 3, 4, 5, 6, 1};
    p4 = 7'b1010111;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_match_a", {31'b0, if_a.match}, 0);
    chk("rst_cnt_a", {24'b0, if_a.match_cnt}, 0);
    chk("rst_prefix_a", {29'b0, if_a.prefix_len}, 0);
    chk("rst_cnt_c", {30'b0, if_c.match_cnt}, 0);
    reset = 1'b0;

    // 1: default pattern walk through the prefix chain
    step(1, 1); chk("t1_p1", {29'b0, if_a.prefix_len}, 1);
    step(1, 0); chk("t1_p2", {29'b0, if_a.prefix_len}, 2);
    step(1, 1); chk("t1_p3", {29'b0, if_a.prefix_len}, 3);
    step(1, 0); chk("t1_p4", {29'b0, if_a.prefix_len}, 4);
    step(1, 1); chk("t1_p5", {29'b0, if_a.prefix_len}, 5);
    step(1, 1); chk("t1_p6", {29'b0, if_a.prefix_len}, 6);
    chk("t1_nomatch_yet", {31'b0, if_a.match}, 0);
    step(1, 1);
    chk("t1_match_a", {31'b0, if_a.match}, 1);
    chk("t1_cnt_a", {24'b0, if_a.match_cnt}, 1);
    chk("t1_prefix_ovl", {29'b0, if_a.prefix_len}, 1);
    chk("t1_match_b", {31'b0, if_b.match}, 1);
    chk("t1_prefix_nov", {29'b0, if_b.prefix_len}, 0);
    step(0, 0);
    chk("t1_pulse_end", {31'b0, if_a.match}, 0);
    chk("t1_cnt_hold", {24'b0, if_a.match_cnt}, 1);

    // 2: 101 followed by 1 falls back to prefix 1
    do_reset();
    step(1, 1); chk("t2_p1", {29'b0, if_a.prefix_len}, 1);
    step(1, 0); chk("t2_p2", {29'b0, if_a.prefix_len}, 2);
    step(1, 1); chk("t2_p3", {29'b0, if_a.prefix_len}, 3);
    step(1, 1); chk("t2_fallback", {29'b0, if_a.prefix_len}, 1);
    chk("t2_no_match", ma, 0);

    // 3: overlap vs non-overlap
    do_reset();
    feed(7'b1010111, 7);
    feed(6'b010111, 6);
    chk("t3_ovl_matches", ma, 2);
    chk("t3_ovl_gap", (pos_a.size() >= 2) ? (pos_a[1] - pos_a[0]) : 0, 6);
    chk("t3_nov_matches", mb, 1);
    chk("t3_nov_prefix", {29'b0, if_b.prefix_len}, 1);
    do_reset();
    feed(7'b1010111, 7);
    feed(7'b1010111, 7);
    chk("t3_nov_two", mb, 2);
    chk("t3_nov_cnt", {24'b0, if_b.match_cnt}, 2);
    chk("t3_ovl_two", ma, 2);

    // 4: 3-cycle in_valid gaps between bits, in toggling as garbage
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1, p4[6 - i]);
      chk("t4_prefix", {29'b0, if_a.prefix_len}, exp4[i]);
      for (int g = 0; g < 3; g++) begin
        step(0, g[0]);
        chk("t4_hold", {29'b0, if_a.prefix_len}, exp4[i]);
        chk("t4_gap_nomatch", {31'b0, if_a.match}, 0);
      end
    end
    chk("t4_single_match", ma, 1);
    chk("t4_cnt", {24'b0, if_a.match_cnt}, 1);

    // 5: runtime pattern reload, then reset restores default pattern
    do_reset();
    feed(3'b101, 3);
    chk("t5_pre_load", {29'b0, if_a.prefix_len}, 3);
    cfg_pattern = 7'b0000001;
    cfg_load = 1'b1;
    step(1, 1);
    cfg_load = 1'b0;
    chk("t5_load_prefix", {29'b0, if_a.prefix_len}, 0);
    chk("t5_load_nomatch", {31'b0, if_a.match}, 0);
    feed(6'b000000, 6);
    chk("t5_p6", {29'b0, if_a.prefix_len}, 6);
    step(1, 1);
    chk("t5_new_match", {31'b0, if_a.match}, 1);
    chk("t5_prefix_after", {29'b0, if_a.prefix_len}, 0);
    do_reset();
    feed(7'b1010111, 7);
    chk("t5_default_back", {31'b0, if_a.match}, 1);

    // 6: saturation, clear with coincident match, async reset mid-pattern, plain clear
    do_reset();
    feed(7'b1010111, 7);
    for (int r = 0; r < 4; r++) feed(6'b010111, 6);
    chk("t6_matches_c", mc, 5);
    chk("t6_cnt_a", {24'b0, if_a.match_cnt}, 5);
    chk("t6_sat_c", {30'b0, if_c.match_cnt}, 3);
    feed(5'b01011, 5);
    cnt_clr = 1'b1;
    step(1, 1);
    cnt_clr = 1'b0;
    chk("t6_clr_match_c", {30'b0, if_c.match_cnt}, 1);
    chk("t6_clr_match_a", {24'b0, if_a.match_cnt}, 1);
    feed(3'b010, 3);
    chk("t6_mid_prefix", {29'b0, if_c.prefix_len}, 4);
    chk("t6_mid_cnt", {30'b0, if_c.match_cnt}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_prefix", {29'b0, if_c.prefix_len}, 0);
    chk("t6_async_cnt", {30'b0, if_c.match_cnt}, 0);
    chk("t6_async_match", {31'b0, if_c.match}, 0);
    chk("t6_async_cnt_a", {24'b0, if_a.match_cnt}, 0);
    reset = 1'b0;
    ma = 0; mb = 0; mc = 0;
    feed(7'b1010111, 7);
    chk("t6_recount", {30'b0, if_c.match_cnt}, 1);
    cnt_clr = 1'b1;
    step(0, 1);
    cnt_clr = 1'b0;
    chk("t6_clr_alone", {30'b0, if_c.match_cnt}, 0);
    chk("t6_clr_prefix_hold", {29'b0, if_c.prefix_len}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
